// File: rtl/lsu_queued.sv
// lsu_queued: in-order load/store queue driving an aligned memory bus.
// Unaligned full-width accesses are split into two aligned beats.
module lsu_queued #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int ID_W   = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic [ADDR_W-1:0] rq_addr,
  input  logic              rq_wr_addr,
  input  logic [DATA_W-1:0] rq_data,
  input  logic              rq_width,
  input  logic              rq_cmd,
  input  logic [ID_W-1:0]   rq_t_id,
  input  logic              rq_start,
  output logic              rq_ack,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cmd,
  output logic [DATA_W/8-1:0] mem_be,
  output logic              mem_bus_assert,
  output logic              rs_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [ID_W-1:0]   rs_t_id
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic              q_width [DEPTH];
  logic              q_cmd [DEPTH];
  logic [ID_W-1:0]   q_id [DEPTH];

  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count, count_nxt;
  logic [ADDR_W-1:0] latch, eff;
  logic              full, push, pop, split;

  logic [ADDR_W-1:0] h_addr, base;
  logic [DATA_W-1:0] h_data;
  logic              h_width, h_cmd;
  logic [ID_W-1:0]   h_id;
  logic [OW-1:0]     off;
  logic [NB-1:0]     lo_mask, beat_be;

  logic [DATA_W-1:0] asm_q, merged, rd_word;

  function automatic logic [DATA_W-1:0] rotl(
    input logic [DATA_W-1:0] d,
    input logic [OW-1:0]     s
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = d[8*((i - int'(s) + NB) % NB) +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rotr(
    input logic [DATA_W-1:0] d,
    input logic [OW-1:0]     s
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = d[8*((i + int'(s)) % NB) +: 8];
    return r;
  endfunction

  // A pop never frees a slot for the same cycle's request.
  assign full   = count == (PW+1)'(DEPTH);
  assign rq_ack = a_rst & rq_start & ~full;
  assign push   = rq_ack;
  assign eff    = rq_wr_addr ? rq_addr : latch;

  assign h_addr  = q_addr[rptr];
  assign h_data  = q_data[rptr];
  assign h_width = q_width[rptr];
  assign h_cmd   = q_cmd[rptr];
  assign h_id    = q_id[rptr];

  assign off     = h_addr[OW-1:0];
  assign base    = {h_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign split   = h_width & (off != '0);
  assign lo_mask = {NB{1'b1}} << off;

  assign mem_bus_assert = state != IDLE;

  assign pop = mem_rdy &
               (((state == BEAT0) & ~split) |
                (state == BEAT1));

  always_comb begin
    beat_be = NB'(1) << off;
    if (h_width)
      beat_be = (state == BEAT1) ? ~lo_mask : lo_mask;
  end

  always_comb begin
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    mem_cmd   = 1'b0;
    if (state != IDLE) begin
      mem_addr  = (state == BEAT1) ? base + ADDR_W'(NB) : base;
      mem_be    = beat_be;
      mem_wdata = rotl(h_data, off);
      mem_cmd   = h_cmd;
    end
  end

  always_comb begin
    merged = asm_q;
    for (int i = 0; i < NB; i++)
      if (mem_be[i]) merged[8*i +: 8] = mem_rdata[8*i +: 8];
  end

  assign rd_word = rotr(merged, off);

  always_comb begin
    count_nxt = count;
    if (push & ~pop)      count_nxt = count + (PW+1)'(1);
    else if (pop & ~push) count_nxt = count - (PW+1)'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (count_nxt != '0) state_nxt = BEAT0;
      BEAT0: if (mem_rdy) begin
        if (split)                 state_nxt = BEAT1;
        else if (count_nxt != '0) state_nxt = BEAT0;
        else                       state_nxt = IDLE;
      end
      BEAT1: if (mem_rdy)
        state_nxt = (count_nxt != '0) ? BEAT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wptr]  <= eff;
      q_data[wptr]  <= rq_data;
      q_width[wptr] <= rq_width;
      q_cmd[wptr]   <= rq_cmd;
      q_id[wptr]    <= rq_t_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      state    <= IDLE;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      latch    <= '0;
      asm_q    <= '0;
      rs_valid <= 1'b0;
      rs_data  <= '0;
      rs_t_id  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) begin
        wptr <= wptr + PW'(1);
        if (rq_wr_addr) latch <= rq_addr;
      end
      if (pop) rptr <= rptr + PW'(1);
      if (mem_bus_assert & mem_rdy & ~h_cmd) asm_q <= merged;
      rs_valid <= pop & ~h_cmd;
      if (pop & ~h_cmd) begin
        rs_data <= h_width ? rd_word
                           : {{(DATA_W-8){1'b0}}, rd_word[7:0]};
        rs_t_id <= h_id;
      end
    end
  end

endmodule

// File: doc/lsu_queued.md
# lsu_queued

Parametrised load/store unit sitting between the core's execute stage and the memory bus. It buffers up to DEPTH requests in an in-order queue and drives them onto the bus one beat at a time. Unaligned full-width accesses are split into two aligned beats. Read data is returned with its transaction id on a response port, so the core can issue new requests while earlier ones are still in flight.

## Interface

Parameters:
- ADDR_W, 16, byte-address width
- DATA_W, 16, bus/data width in bits; multiple of 8, power of two, ≥16; NB = DATA_W/8 byte lanes
- ID_W, 1, transaction id width
- DEPTH, 4, request queue entries; power of two, ≥2

Ports:
- clk  in  1  clock, all state on rising edge
- a_rst  in  1  reset, synchronous, active-low
- rq_addr  in  ADDR_W  request byte address
- rq_wr_addr  in  1  1: use rq_addr and update address latch; 0: reuse latched address
- rq_data  in  DATA_W  write data, right-justified (byte in bits 7:0)
- rq_width  in  1  0 = byte, 1 = full word
- rq_cmd  in  1  0 = read, 1 = write
- rq_t_id  in  ID_W  transaction id
- rq_start  in  1  request valid
- rq_ack  out  1  request accepted this cycle (combinational)
- mem_rdy  in  1  bus completes current beat this cycle
- mem_rdata  in  DATA_W  bus read data, valid when mem_rdy
- mem_addr  out  ADDR_W  beat address, always NB-aligned
- mem_wdata  out  DATA_W  write data, lane-positioned
- mem_cmd  out  1  0 = read, 1 = write
- mem_be  out  NB  byte-lane enables
- mem_bus_assert  out  1  beat presented
- rs_valid  out  1  read response pulse
- rs_data  out  DATA_W  read data, right-justified; byte reads zero-extended
- rs_t_id  out  ID_W  id of the returned read

## Operation

- Address latch: on an accepted request with rq_wr_addr=1, latch ← rq_addr. The effective address of every accepted request is rq_wr_addr ? rq_addr : latch (pre-update value).
- Queue: FIFO of {eff addr, data, width, cmd, t_id}. rq_ack = rq_start & ~full. While full, rq_ack=0, even if a pop happens in the same cycle. Push and pop in the same cycle when not full: count unchanged.
- Head decode: off = addr mod NB; base = addr − off.
  - Byte: single beat, mem_be bit off only.
  - Word with off=0: single beat, all lanes.
  - Word with off≠0: two beats. Beat 0 at base, lanes off..NB−1. Beat 1 at base+NB (wraps mod 2^ADDR_W), lanes 0..off−1.
- Write data is rotated left by off bytes so each byte lands on its own lane; both beats carry the same rotated word.
- Beat FSM states: IDLE (queue empty), BEAT0, BEAT1.
  - IDLE→BEAT0 when the queue becomes non-empty.
  - BEAT0 with mem_rdy: split → BEAT1; otherwise pop, then go to BEAT0 if entries remain, else IDLE.
  - BEAT1 with mem_rdy: pop, then go to BEAT0 or IDLE by the same rule.
- Reads: lanes enabled in each beat are captured into an assembly register from mem_rdata. On completion the assembled word is rotated right by off and written to rs_data (byte: zero-extend lane off). rs_valid pulses and rs_t_id = head t_id.
- Writes produce no response.
- mem_bus_assert = state ≠ IDLE. mem_addr, mem_wdata, mem_cmd and mem_be are decoded combinationally from the head entry and the current state, and are stable while mem_rdy=0.

## Timing

- Reset (a_rst=0 at a clock edge): queue empty, state IDLE, latch=0, rs_valid=0, rs_data=0, rs_t_id=0. Consequently mem_bus_assert=0, mem_be=0, mem_addr=0, mem_wdata=0, mem_cmd=0 after the edge.
- rq_ack is 0 throughout reset.
- Reset mid-transaction discards all queued and in-flight requests; no response is issued for them.
- Latency: a request accepted at edge N into an empty queue is presented (mem_bus_assert=1) in cycle N+1.
- A single-beat access with mem_rdy=1 in cycle N+1 pops at edge N+2. For a read, rs_valid=1 during cycle N+2 (one cycle after the completing beat).
- A split access adds one beat.
- Back-to-back: the next head is presented in the cycle immediately after the pop, with no bubble.
- rs_valid is exactly one cycle per read. Responses are in request order.

## Test plan

- Aligned word write 0x1234 to 0x0040 with mem_rdy tied 1 → cycle after ack: mem_addr=0x0040, mem_be=2'b11, mem_wdata=0x1234, mem_cmd=1; one beat; no rs_valid.
- Byte read at 0x0041, t_id=1, mem_rdata=0xAB00 → mem_be=2'b10; next cycle rs_valid=1, rs_data=0x00AB, rs_t_id=1.
- Unaligned word read at 0x0043, rdata beat0=0x7700, beat1=0x0066 → beats at 0x0042 (be=10) then 0x0044 (be=01); rs_data=0x6677.
- Unaligned write 0xBEEF at 0xFFFF → beat0 addr 0xFFFE be=10 wdata=0xEFBE; beat1 addr 0x0000 be=01 (wrap).
- Queue full: DEPTH+1 back-to-back rq_start with mem_rdy=0 → first DEPTH acked, next rq_ack=0 until first pop. Then a request with rq_wr_addr=0 reuses the last written address.
- Reset asserted while BEAT1 pending → next cycle mem_bus_assert=0, no rs_valid; the first request after reset is served normally.
